sfr_mc: RTL



---
 rtl/sfr_mc.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sfr_mc.sv
// sfr_mc: register block for a multi-core tile with per-core resets, an MSI FIFO, a cycle counter and a scratch register.
// Optional macro SFR_MC_CYCLE_SNAPSHOT_EN: CYCLE_HI returns cycle[63:32] as latched by the last CYCLE_LO read.
module sfr_mc #(
    parameter int unsigned CORENUM            = 0,
    parameter int unsigned NUM_CORES          = 1,
    parameter bit          CPU_RESET_DEFAULT  = 1'b0,
    parameter int unsigned IRQ_NUM_POW        = 4,
    parameter int unsigned MSI_FIFO_DEPTH_POW = 2,
    // Power-on value of the cycle counter; nonzero values let a 32-bit carry be reached quickly.
    parameter logic [63:0] CYCLE_INIT         = 64'd0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        host_req_i,
    input  logic                        host_we_i,
    input  logic [31:0]                 host_addr_bi,
    input  logic [31:0]                 host_wdata_bi,
    output logic                        host_ack_o,
    output logic                        host_resp_o,
    output logic [31:0]                 host_rdata_bo,
    output logic [NUM_CORES-1:0]        cpu_reset_o,
    output logic                        msi_req_o,
    output logic [2**IRQ_NUM_POW-1:0]   msi_code_bo,
    input  logic                        msi_ack_i
);

    localparam int unsigned      CODE_W  = 2 ** IRQ_NUM_POW;
    localparam int unsigned      DEPTH   = 2 ** MSI_FIFO_DEPTH_POW;
    localparam int unsigned      PTR_W   = MSI_FIFO_DEPTH_POW;
    localparam int unsigned      LVL_W   = MSI_FIFO_DEPTH_POW + 1;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
    localparam logic [31:0]      IDCODE  = 32'h5F52_0002;

    localparam logic [7:0] ADDR_IDCODE   = 8'h00;
    localparam logic [7:0] ADDR_CTRL     = 8'h04;
    localparam logic [7:0] ADDR_CORENUM  = 8'h08;
    localparam logic [7:0] ADDR_MSI      = 8'h0C;
    localparam logic [7:0] ADDR_MSI_STAT = 8'h10;
    localparam logic [7:0] ADDR_CYCLE_LO = 8'h14;
    localparam logic [7:0] ADDR_CYCLE_HI = 8'h18;
    localparam logic [7:0] ADDR_SCRATCH  = 8'h1C;

    // Handshakes: the host bus accepts a request in any cycle host_req_i is high (host_ack_o
    // mirrors it) and answers a read with a one-cycle host_resp_o pulse on the following cycle;
    // the MSI port presents msi_req_o/msi_code_bo while the FIFO holds an entry, and the head is
    // consumed on every clock edge where msi_req_o && msi_ack_i.
    logic [7:0]           addr;
    logic                 wr_en;
    logic                 rd_en;
    logic [31:0]          rd_data;
    logic [31:0]          cycle_hi_rd;
    logic [23:0]          unused_addr;

    logic [CODE_W-1:0]    fifo_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic [31:0]          level_ext;
    logic [15:0]          drop_cnt;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 msi_push;
    logic                 msi_pop;
    logic                 push_ok;
    logic                 msi_drop;
    logic                 stat_wr;

    logic [NUM_CORES-1:0] ctrl_q;
    logic [63:0]          cycle_q;
    logic [31:0]          scratch_q;

    assign addr        = host_addr_bi[7:0];
    assign unused_addr = host_addr_bi[31:8];
    assign wr_en       = host_req_i & host_we_i;
    assign rd_en       = host_req_i & ~host_we_i;
    assign host_ack_o  = host_req_i;

    assign fifo_empty  = (level == '0);
    assign fifo_full   = (level == DEPTH_L);
    assign level_ext   = 32'(level);
    assign msi_req_o   = ~fifo_empty;
    assign msi_code_bo = fifo_mem[rd_ptr];
    assign msi_pop     = ~fifo_empty & msi_ack_i;
    assign msi_push    = wr_en & (addr == ADDR_MSI);
    // A pop on the same edge frees the slot, so a push into a full FIFO is only lost without one.
    assign push_ok     = msi_push & (~fifo_full | msi_pop);
    assign msi_drop    = msi_push & fifo_full & ~msi_pop;
    assign stat_wr     = wr_en & (addr == ADDR_MSI_STAT);

`ifdef SFR_MC_CYCLE_SNAPSHOT_EN
    logic [31:0] cycle_hi_shadow;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_hi_shadow <= '0;
        end else if (rd_en && addr == ADDR_CYCLE_LO) begin
            cycle_hi_shadow <= cycle_q[63:32];
        end
    end

    assign cycle_hi_rd = cycle_hi_shadow;
`else
    assign cycle_hi_rd = cycle_q[63:32];
`endif

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_IDCODE:   rd_data = IDCODE;
            ADDR_CTRL:     rd_data = 32'(ctrl_q);
            ADDR_CORENUM:  rd_data = 32'(CORENUM);
            ADDR_MSI_STAT: rd_data = {drop_cnt, 8'h00, fifo_full, fifo_empty, 1'b0, level_ext[4:0]};
            ADDR_CYCLE_LO: rd_data = cycle_q[31:0];
            ADDR_CYCLE_HI: rd_data = cycle_hi_rd;
            ADDR_SCRATCH:  rd_data = scratch_q;
            default:       rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            host_resp_o   <= 1'b0;
            host_rdata_bo <= '0;
        end else begin
            host_resp_o <= rd_en;
            if (rd_en) begin
                host_rdata_bo <= rd_data;
            end
        end
    end

    // Cores stay held in reset while rst_i is high, whatever the CTRL default is.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q      <= {NUM_CORES{CPU_RESET_DEFAULT}};
            cpu_reset_o <= '1;
            scratch_q   <= '0;
            cycle_q     <= CYCLE_INIT;
        end else begin
            cpu_reset_o <= ctrl_q;
            cycle_q     <= cycle_q + 64'd1;
            if (wr_en && addr == ADDR_CTRL) begin
                ctrl_q <= host_wdata_bi[NUM_CORES-1:0];
            end
            if (wr_en && addr == ADDR_SCRATCH) begin
                scratch_q <= host_wdata_bi;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= host_wdata_bi[CODE_W-1:0];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (msi_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !msi_pop) begin
                level <= level + 1'b1;
            end else if (!push_ok && msi_pop) begin
                level <= level - 1'b1;
            end
            // A clear coinciding with a drop leaves that drop counted.
            if (stat_wr) begin
                drop_cnt <= msi_drop ? 16'd1 : 16'd0;
            end else if (msi_drop && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule
